// File: rtl/riscv_muldiv_seq.sv
// riscv_muldiv_seq -- iterative RV32M/RV64M multiply/divide unit.
//
// Executes the eight M-extension operations selected by funct3 over XLEN+2
// cycles (radix-2 shift-add multiply or restoring divide on operand
// magnitudes, then a sign-fix cycle). One operation is in flight at a time.
// With FAST_SPEC=1, divide-by-zero and signed-overflow divides skip the
// iteration and complete on the accepting edge.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   start         request valid, accepted when ready=1
//   ready         unit idle, can accept a request
//   funct3        000 mul, 001 mulh, 010 mulhsu, 011 mulhu,
//                 100 div, 101 divu, 110 rem, 111 remu
//   a, b          rs1 / rs2 operands, latched on the accepting edge
//   flush         synchronous abort to IDLE, discards any result
//   result_valid  result presented (state DONE)
//   result_ready  consumer takes the result
//   result        operation result, 0 outside DONE
//   busy          state != IDLE
module riscv_muldiv_seq #(
    parameter int XLEN      = 32,
    parameter bit FAST_SPEC = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            result_valid,
    input  logic            result_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_e;

    // Operand a is treated as signed for mul, mulh, mulhsu, div, rem.
    function automatic logic op_a_signed(input logic [2:0] op);
        return op[2] ? !op[0] : (op[1:0] != 2'b11);
    endfunction

    // Operand b is treated as signed for mul, mulh, div, rem.
    function automatic logic op_b_signed(input logic [2:0] op);
        return op[2] ? !op[0] : !op[1];
    endfunction

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic neg);
        return neg ? ('0 - x) : x;
    endfunction

    // Divide by zero, or the single signed quotient that does not fit.
    function automatic logic spec_hit(input logic is_div, input logic is_unsigned,
                                      input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        logic ovf;
        ovf = !is_unsigned && (x == MIN_NEG) && (y == '1);
        return is_div && ((y == '0) || ovf);
    endfunction

    // Architected results for the special cases: x/0 = all ones, x%0 = x,
    // MIN/-1 = MIN, MIN%-1 = 0.
    function automatic logic [XLEN-1:0] spec_val(input logic is_rem,
                                                 input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        if (y == '0) begin
            return is_rem ? x : '1;
        end
        return is_rem ? '0 : x;
    endfunction

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] hi_q, hi_d;      // mul: upper partial product; div: remainder
    logic [XLEN-1:0] lo_q, lo_d;      // mul: multiplier / low product; div: dividend / quotient
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;

    // Request-side decode, used only on the accepting edge.
    logic            in_hit;
    logic [XLEN-1:0] in_val;
    logic [XLEN-1:0] in_ma, in_mb;

    assign in_hit = spec_hit(funct3[2], funct3[0], a, b);
    assign in_val = spec_val(funct3[1], a, b);
    assign in_ma  = magnitude(a, op_a_signed(funct3) & a[XLEN-1]);
    assign in_mb  = magnitude(b, op_b_signed(funct3) & b[XLEN-1]);

    // Latched-operand decode, used during RUN and FIX.
    logic            sa, sb;
    logic [XLEN-1:0] mag_a, mag_b;

    assign sa    = op_a_signed(op_q) & a_q[XLEN-1];
    assign sb    = op_b_signed(op_q) & b_q[XLEN-1];
    assign mag_a = magnitude(a_q, sa);
    assign mag_b = magnitude(b_q, sb);

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] prod_mag, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fix_val;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        // One shift-add step: add |a| when the current multiplier bit is set,
        // then shift the whole {hi,lo} product right by one.
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_a} : '0);

        // One restoring-divide step: shift the next dividend bit into the
        // remainder and subtract |b|; a clear sign bit means it fits.
        div_trial = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_trial - {1'b0, mag_b};

        prod_mag  = {hi_q, lo_q};
        prod_s    = (sa ^ sb) ? ('0 - prod_mag) : prod_mag;
        quo_s     = (sa ^ sb) ? ('0 - lo_q) : lo_q;
        rem_s     = sa ? ('0 - hi_q) : hi_q;   // truncating: remainder follows a

        if (op_q[2]) begin
            if (spec_hit(1'b1, op_q[0], a_q, b_q)) begin
                fix_val = spec_val(op_q[1], a_q, b_q);
            end else begin
                fix_val = op_q[1] ? rem_s : quo_s;
            end
        end else begin
            fix_val = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = funct3;
                    a_d   = a;
                    b_d   = b;
                    cnt_d = '0;
                    hi_d  = '0;
                    lo_d  = funct3[2] ? in_ma : in_mb;
                    if (FAST_SPEC && in_hit) begin
                        result_d = in_val;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (op_q[2]) begin
                    if (!div_diff[XLEN]) begin
                        hi_d = div_diff[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = div_trial[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    hi_d = mul_sum[XLEN:1];
                    lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            S_FIX: begin
                result_d = fix_val;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (result_ready) begin
                    result_d = '0;
                    state_d  = S_IDLE;
                end
            end
        endcase

        // Abort overrides every transition, including acceptance in IDLE.
        if (flush) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = '0;
        end

        // Outputs are registered as a decode of the next state.
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        valid_d = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign ready        = ready_q;
    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign result       = result_q;

endmodule

// File: tb/tb_riscv_muldiv_seq.sv
// tb_riscv_muldiv_seq -- scoreboard bench for riscv_muldiv_seq (XLEN=32).
//
// Two instances share all inputs: dut_fast (FAST_SPEC=1) and dut_full
// (FAST_SPEC=0). The driver pushes hand-computed expected results and
// latencies into one queue per instance; a monitor on the falling edge pops
// and compares whenever result_valid rises, and checks the ready/busy/result
// relationships every cycle. Latency counts the accepting edge as edge 1.
module tb_riscv_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic        result_ready;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;

    logic        rdy [2];
    logic        rv  [2];
    logic        bsy [2];
    logic [31:0] res [2];

    always #5 clk = ~clk;

    riscv_muldiv_seq #(.XLEN(32), .FAST_SPEC(1'b1)) dut_fast (
        .clk(clk), .reset(reset), .start(start), .ready(rdy[0]), .funct3(funct3),
        .a(a), .b(b), .flush(flush), .result_valid(rv[0]), .result_ready(result_ready),
        .result(res[0]), .busy(bsy[0])
    );

    riscv_muldiv_seq #(.XLEN(32), .FAST_SPEC(1'b0)) dut_full (
        .clk(clk), .reset(reset), .start(start), .ready(rdy[1]), .funct3(funct3),
        .a(a), .b(b), .flush(flush), .result_valid(rv[1]), .result_ready(result_ready),
        .result(res[1]), .busy(bsy[1])
    );

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef struct {
        logic [31:0] val;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t mon_e;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic rv_prev [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle output relationships plus scoreboard pops.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("ready_vs_busy%0d", i), {31'd0, rdy[i]}, {31'd0, ~bsy[i]});
            if (!rv[i]) begin
                check($sformatf("result_zero_idle%0d", i), res[i], 32'd0);
            end
            if (rv[i] && !rv_prev[i]) begin
                if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result dut%0d: got %h expected none", i, res[i]);
                end else begin
                    if (i == 0) mon_e = q0.pop_front();
                    else        mon_e = q1.pop_front();
                    check($sformatf("%s_val%0d", mon_e.name, i), res[i], mon_e.val);
                    check($sformatf("%s_lat%0d", mon_e.name, i), cyc - mon_e.acc + 1, mon_e.lat);
                end
            end
            rv_prev[i] <= rv[i];
        end
    end

    // Present a request for one cycle; no expectation is recorded.
    task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        funct3 = op;
        a      = av;
        b      = bv;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = 3'($urandom);
        a      = $urandom;
        b      = $urandom;
    endtask

    // Issue and record the expected result for both instances.
    task automatic send(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ev, input bit spec, input string nm);
        issue(op, av, bv);
        check({nm, "_accepted"}, {30'd0, rdy[0], rdy[1]}, 32'd0);
        q0.push_back('{ev, spec ? 1 : 34, cyc, nm});
        q1.push_back('{ev, 34, cyc, nm});
    endtask

    // Wait, bounded, until both instances are idle with nothing outstanding.
    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (!(rdy[0] && rdy[1] && q0.size() == 0 && q1.size() == 0) && n < 200) begin
            @(negedge clk);
            if (q0.size() != 0) check({nm, "_ready_low0"}, {31'd0, rdy[0]}, 32'd0);
            if (q1.size() != 0) check({nm, "_ready_low1"}, {31'd0, rdy[1]}, 32'd0);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got busy after 200 cycles expected idle", nm);
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ev, input bit spec, input string nm);
        send(op, av, bv, ev, spec, nm);
        wait_idle(nm);
    endtask

    task automatic check_idle(input string nm);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_ready%0d", nm, i), {31'd0, rdy[i]}, 32'd1);
            check($sformatf("%s_valid%0d", nm, i), {31'd0, rv[i]},  32'd0);
            check($sformatf("%s_busy%0d",  nm, i), {31'd0, bsy[i]}, 32'd0);
            check($sformatf("%s_result%0d", nm, i), res[i], 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset        = 1'b0;
        start        = 1'b0;
        flush        = 1'b0;
        result_ready = 1'b1;
        funct3       = 3'b000;
        a            = '0;
        b            = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b1;
        @(negedge clk);

        // Multiply family.
        run(OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, "mul_7_m3");
        run(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0, "mulh_min_min");
        run(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "mulhu_max");
        run(OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, "mulhsu_m1_2");
        run(OP_MULHU,  32'h80000000, 32'd2,        32'd1,        1'b0, "mulhu_carry");

        // Divide family.
        run(OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, "div_m7_2");
        run(OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, "rem_m7_2");
        run(OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, "div_7_m2");
        run(OP_REM,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, "rem_m7_m2");
        run(OP_DIVU,   32'd100,      32'd7,        32'd14,       1'b0, "divu_100_7");
        run(OP_REMU,   32'd100,      32'd7,        32'd2,        1'b0, "remu_100_7");

        // Special divides: fast instance 1 edge, full instance 34 edges.
        run(OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, "divu_by0");
        run(OP_REM,    32'd5,        32'd0,        32'd5,        1'b1, "rem_by0");
        run(OP_DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1'b1, "div_neg_by0");
        run(OP_REMU,   32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 1'b1, "remu_by0");
        run(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "div_ovf");
        run(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1, "rem_ovf");

        // Back-pressure: result held while result_ready is low, start ignored.
        result_ready = 1'b0;
        send(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "hold");
        n = 0;
        while (!(rv[0] && rv[1]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL hold_wait_valid: got no result_valid expected valid within 100");
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            start  = k[0];
            funct3 = OP_DIVU;
            a      = 32'd9;
            b      = 32'd3;
            for (int i = 0; i < 2; i++) begin
                check($sformatf("hold_result%0d", i), res[i], 32'hFFFFFFFE);
                check($sformatf("hold_valid%0d", i),  {31'd0, rv[i]},  32'd1);
                check($sformatf("hold_ready%0d", i),  {31'd0, rdy[i]}, 32'd0);
            end
        end
        @(negedge clk);
        start        = 1'b0;
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        check_idle("hold_release");
        @(negedge clk);

        // Flush during RUN cycle 5.
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_idle("flush_run");
        repeat (40) @(negedge clk);
        check_idle("flush_quiet");

        // Flush together with start in IDLE: request must be dropped.
        @(negedge clk);
        funct3 = OP_MUL;
        a      = 32'd3;
        b      = 32'd4;
        start  = 1'b1;
        flush  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        flush  = 1'b0;
        check_idle("flush_start");
        repeat (40) @(negedge clk);

        // Asynchronous reset in the middle of RUN.
        issue(OP_MUL, 32'd12345, 32'd678);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_idle("reset_mid_run");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run(OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, "divu_after_reset");

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
